// File: rtl/instr_ram_loader_if.sv
// Stream-in and RAM-write bundle for the instruction RAM loader.
// The slave modport is the loader's view; master is the stream source / RAM side.
interface instr_ram_loader_if #(
  parameter int ADDR_W = 8
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;

  modport master (
    output in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_ram_loader.sv
// Length-prefixed byte-stream loader for the instruction RAM; holds the core in reset until done.
// Define LOADER_CHECKSUM_EN to require a trailing checksum byte (8-bit sum of all bytes == 0).
module instr_ram_loader #(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              Reset,
  instr_ram_loader_if.slave bus,
  input  logic              restart,
  output logic              core_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   bytes_written
);

  typedef enum logic [2:0] {
    S_LEN,
    S_DATA,
`ifdef LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE,
    S_ERR
  } state_t;

  state_t            state;
  logic [8:0]        remaining;
  logic [ADDR_W-1:0] ptr;
  logic              xfer;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum;
  logic [7:0] csum_total;
  assign csum_total = sum + bus.in_data;
`else
  assign error = 1'b0;
`endif

`ifdef LOADER_CHECKSUM_EN
  assign bus.in_ready = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
`else
  assign bus.in_ready = (state == S_LEN) || (state == S_DATA);
`endif

  assign xfer = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state         <= S_LEN;
      remaining     <= 9'd0;
      ptr           <= BASE_ADDR;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= BASE_ADDR;
      bus.mem_wdata <= 8'd0;
      core_hold     <= 1'b1;
      done          <= 1'b0;
      bytes_written <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum           <= 8'd0;
      error         <= 1'b0;
`endif
    end else begin
      bus.mem_we <= 1'b0;
      case (state)
        S_LEN: begin
          if (xfer) begin
            // A length byte of zero encodes a full 256-byte load.
            remaining     <= (bus.in_data == 8'd0) ? 9'd256 : {1'b0, bus.in_data};
            bytes_written <= '0;
            ptr           <= BASE_ADDR;
`ifdef LOADER_CHECKSUM_EN
            sum           <= bus.in_data;
`endif
            state         <= S_DATA;
          end
        end
        S_DATA: begin
          if (xfer) begin
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= ptr;
            bus.mem_wdata <= bus.in_data;
            ptr           <= ptr + ADDR_W'(1);
            bytes_written <= bytes_written + (ADDR_W+1)'(1);
            remaining     <= remaining - 9'd1;
`ifdef LOADER_CHECKSUM_EN
            sum           <= sum + bus.in_data;
            if (remaining == 9'd1) state <= S_CSUM;
`else
            if (remaining == 9'd1) begin
              state     <= S_DONE;
              done      <= 1'b1;
              core_hold <= 1'b0;
            end
`endif
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (xfer) begin
            if (csum_total == 8'd0) begin
              state     <= S_DONE;
              done      <= 1'b1;
              core_hold <= 1'b0;
            end else begin
              state <= S_ERR;
              error <= 1'b1;
            end
          end
        end
`endif
        S_DONE, S_ERR: begin
          if (restart) begin
            state     <= S_LEN;
            done      <= 1'b0;
            core_hold <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            error     <= 1'b0;
`endif
          end
        end
        default: state <= S_LEN;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_ram_loader.sv
// Randomized self-checking bench for instr_ram_loader against a transaction-level load model.
// Checksum scenarios are included when LOADER_CHECKSUM_EN is defined.
module tb_instr_ram_loader;
  localparam int BASE = 0;

  logic       clk = 1'b0;
  logic       Reset;
  logic       restart;
  logic       core_hold;
  logic       done;
  logic       error;
  logic [8:0] bytes_written;

  instr_ram_loader_if #(.ADDR_W(8)) bus();

  instr_ram_loader #(.ADDR_W(8), .BASE_ADDR(8'(BASE))) dut (
    .clk           (clk),
    .Reset         (Reset),
    .bus           (bus),
    .restart       (restart),
    .core_hold     (core_hold),
    .done          (done),
    .error         (error),
    .bytes_written (bytes_written)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Load model: progress is tracked as "length seen / payload count / verdict".
  bit         m_have_len;
  int         m_total;
  int         m_written;
  int         m_sum;
  bit         m_finished;
  bit         m_ok;
  logic       m_we;
  logic [7:0] m_addr;
  logic [7:0] m_wd;

  logic [7:0] ram [256];
  int         nwrites = 0;
  logic [7:0] pl [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_have_len = 1'b0;
    m_total    = 0;
    m_written  = 0;
    m_sum      = 0;
    m_finished = 1'b0;
    m_ok       = 1'b1;
    m_we       = 1'b0;
    m_addr     = 8'(BASE);
    m_wd       = 8'd0;
  endtask

  task automatic model_step();
    logic nwe;
    nwe = 1'b0;
    if (Reset) begin
      model_reset();
      return;
    end
    if (bus.in_valid && !m_finished) begin
      if (!m_have_len) begin
        m_total    = (bus.in_data == 8'd0) ? 256 : int'(bus.in_data);
        m_have_len = 1'b1;
        m_written  = 0;
        m_sum      = int'(bus.in_data);
      end else if (m_written < m_total) begin
        nwe       = 1'b1;
        m_addr    = 8'((BASE + m_written) % 256);
        m_wd      = bus.in_data;
        m_written = m_written + 1;
        m_sum     = m_sum + int'(bus.in_data);
`ifndef LOADER_CHECKSUM_EN
        if (m_written == m_total) begin
          m_finished = 1'b1;
          m_ok       = 1'b1;
        end
`endif
      end else begin
        m_finished = 1'b1;
        m_ok       = ((m_sum + int'(bus.in_data)) % 256) == 0;
      end
    end else if (restart && m_finished) begin
      m_finished = 1'b0;
      m_have_len = 1'b0;
    end
    m_we = nwe;
  endtask

  task automatic compare_cycle();
    chk("in_ready",      32'(bus.in_ready),  32'(!m_finished));
    chk("mem_we",        32'(bus.mem_we),    32'(m_we));
    chk("mem_addr",      32'(bus.mem_addr),  32'(m_addr));
    chk("mem_wdata",     32'(bus.mem_wdata), 32'(m_wd));
    chk("done",          32'(done),          32'(m_finished && m_ok));
    chk("error",         32'(error),         32'(m_finished && !m_ok));
    chk("core_hold",     32'(core_hold),     32'(!(m_finished && m_ok)));
    chk("bytes_written", 32'(bytes_written), 32'(m_written));
  endtask

  task automatic tick();
    @(negedge clk);
    compare_cycle();
    if (bus.mem_we === 1'b1) begin
      ram[bus.mem_addr] = bus.mem_wdata;
      nwrites++;
    end
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int guard;
    bit acc;
    if (gaps) begin
      while ($urandom_range(0, 2) == 0) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        restart      = ($urandom_range(0, 4) == 0);
        tick();
        restart = 1'b0;
      end
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    guard = 0;
    acc   = 1'b0;
    while (!acc && guard < 100) begin
      acc = bus.in_ready;
      tick();
      guard++;
    end
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: byte %0h not accepted within 100 cycles", b);
    end
  endtask

  task automatic run_load(input logic [7:0] len, input bit gaps, input bit corrupt);
    int s;
    s = int'(len);
    send_byte(len, gaps);
    foreach (pl[i]) begin
      send_byte(pl[i], gaps);
      s += int'(pl[i]);
    end
`ifdef LOADER_CHECKSUM_EN
    begin
      logic [7:0] c;
      c = 8'((256 - (s % 256)) % 256);
      if (corrupt) c = c + 8'd1;
      send_byte(c, gaps);
    end
`else
    if (corrupt) s = 0;
`endif
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    int bad;
    int len;

    Reset        = 1'b1;
    restart      = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'd0;
    for (int i = 0; i < 256; i++) ram[i] = 8'hXX;
    model_reset();
    idle(2);
    Reset = 1'b0;
    chk("rst_in_ready",      32'(bus.in_ready),  32'd1);
    chk("rst_mem_we",        32'(bus.mem_we),    32'd0);
    chk("rst_mem_addr",      32'(bus.mem_addr),  32'd0);
    chk("rst_mem_wdata",     32'(bus.mem_wdata), 32'd0);
    chk("rst_core_hold",     32'(core_hold),     32'd1);
    chk("rst_done",          32'(done),          32'd0);
    chk("rst_error",         32'(error),         32'd0);
    chk("rst_bytes_written", 32'(bytes_written), 32'd0);
    idle(1);

    // Basic load
    pl = '{8'hE0, 8'h82, 8'h50, 8'h05};
    w0 = nwrites;
    run_load(8'h04, 1'b0, 1'b0);
    chk("basic_done",      32'(done),          32'd1);
    chk("basic_core_hold", 32'(core_hold),     32'd0);
    chk("basic_bw",        32'(bytes_written), 32'd4);
    idle(2);
    chk("basic_ram0",   32'(ram[0]), 32'hE0);
    chk("basic_ram1",   32'(ram[1]), 32'h82);
    chk("basic_ram2",   32'(ram[2]), 32'h50);
    chk("basic_ram3",   32'(ram[3]), 32'h05);
    chk("basic_writes", 32'(nwrites - w0), 32'd4);

    // Ignored input while DONE
    w0 = nwrites;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.in_data = 8'($urandom);
      tick();
    end
    bus.in_valid = 1'b0;
    chk("ignored_writes",   32'(nwrites - w0), 32'd0);
    chk("ignored_in_ready", 32'(bus.in_ready), 32'd0);
    pulse_restart();
    chk("restart_core_hold", 32'(core_hold),    32'd1);
    chk("restart_done",      32'(done),         32'd0);
    chk("restart_in_ready",  32'(bus.in_ready), 32'd1);

    // Backpressure and gaps
    for (int i = 0; i < 4; i++) ram[i] = 8'h00;
    w0 = nwrites;
    run_load(8'h04, 1'b1, 1'b0);
    idle(2);
    chk("gaps_writes", 32'(nwrites - w0), 32'd4);
    chk("gaps_ram0",   32'(ram[0]), 32'hE0);
    chk("gaps_ram3",   32'(ram[3]), 32'h05);
    chk("gaps_done",   32'(done),   32'd1);

    // Full 256-byte load
    pulse_restart();
    pl.delete();
    for (int i = 0; i < 256; i++) pl.push_back(8'(i));
    w0 = nwrites;
    run_load(8'h00, 1'b0, 1'b0);
    chk("full_bw",   32'(bytes_written), 32'd256);
    chk("full_done", 32'(done),          32'd1);
    idle(2);
    chk("full_writes", 32'(nwrites - w0), 32'd256);
    bad = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== 8'(i)) bad++;
    chk("full_ram_mismatches", 32'(bad), 32'd0);

    // Reset in the middle of the payload
    pulse_restart();
    send_byte(8'h04, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    Reset = 1'b1;
    model_reset();
    #1;
    chk("midrst_mem_we",    32'(bus.mem_we),    32'd0);
    chk("midrst_bw",        32'(bytes_written), 32'd0);
    chk("midrst_core_hold", 32'(core_hold),     32'd1);
    chk("midrst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("midrst_mem_addr",  32'(bus.mem_addr),  32'd0);
    tick();
    Reset = 1'b0;
    tick();
    pl = '{8'hAA, 8'hBB};
    run_load(8'h02, 1'b0, 1'b0);
    idle(2);
    chk("reload_ram0", 32'(ram[0]), 32'hAA);
    chk("reload_ram1", 32'(ram[1]), 32'hBB);
    chk("reload_ram2", 32'(ram[2]), 32'h02);
    chk("reload_bw",   32'(bytes_written), 32'd2);

`ifdef LOADER_CHECKSUM_EN
    pulse_restart();
    pl = '{8'h10, 8'h20};
    run_load(8'h02, 1'b0, 1'b0);
    chk("csum_ok_done", 32'(done), 32'd1);
    pulse_restart();
    run_load(8'h02, 1'b0, 1'b1);
    chk("csum_bad_error",     32'(error),     32'd1);
    chk("csum_bad_core_hold", 32'(core_hold), 32'd1);
    chk("csum_bad_done",      32'(done),      32'd0);
    pulse_restart();
    chk("csum_restart_error", 32'(error), 32'd0);
    pl = '{8'h55};
    run_load(8'h01, 1'b0, 1'b0);
    chk("csum_after_restart_done", 32'(done), 32'd1);
`endif

    // Randomized loads with gaps, stray restarts and (with checksum) occasional corruption
    for (int k = 0; k < 6; k++) begin
      pulse_restart();
      len = $urandom_range(1, 40);
      pl.delete();
      for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
      run_load(8'(len), 1'b1, ($urandom_range(0, 3) == 0));
      chk("rand_bw", 32'(bytes_written), 32'(len));
      bus.in_valid = 1'b1;
      bus.in_data  = 8'($urandom);
      idle($urandom_range(1, 4));
      bus.in_valid = 1'b0;
    end
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
